// File: rtl/matrix_bcd_loader_pkg.sv
// Shared definitions for the matrix BCD loader and the display top:
// FSM encoding, element count and digit-slot addressing.
package matrix_bcd_loader_pkg;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_READ   = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_CONV   = 3'd3;
    localparam logic [2:0] S_STORE  = 3'd4;
    localparam logic [2:0] S_PEND   = 3'd5;
    localparam logic [2:0] S_COMMIT = 3'd6;

    localparam int unsigned MATRIX_N_DEF = 3;
    localparam int unsigned MATRIX_M_DEF = 3;
    localparam int unsigned NUM_MATS_DEF = 3;
    localparam int unsigned E_DEF = NUM_MATS_DEF * MATRIX_N_DEF * MATRIX_M_DEF;

    function automatic int unsigned elem_count(
        input int unsigned nmats,
        input int unsigned n,
        input int unsigned m
    );
        return nmats * n * m;
    endfunction

    // Bus is laid out row-major across all matrices, digit 0 = MSD
    function automatic int unsigned slot_base(
        input int unsigned i,
        input int unsigned j,
        input int unsigned k,
        input int unsigned l,
        input int unsigned nmats,
        input int unsigned m,
        input int unsigned digits
    );
        return (((i * nmats + j) * m + k) * digits + l) * 4;
    endfunction

endpackage

// File: rtl/matrix_bcd_loader_dabble.sv
// One double-dabble iteration: add 3 to nibbles >= 5, then shift
// the concatenated {bcd, bin} left by one bit.
module bcd_dabble_step
    import matrix_bcd_loader_pkg::*;
#(
    parameter int DIGITS = 5,
    parameter int DATA_W = 16
) (
    input  logic [DIGITS*4-1:0] bcd_i,
    input  logic [DATA_W-1:0]   bin_i,
    output logic [DIGITS*4-1:0] bcd_o,
    output logic [DATA_W-1:0]   bin_o
);

    logic [DIGITS*4-1:0] adj;

    always_comb begin
        adj = bcd_i;
        for (int d = 0; d < DIGITS; d++) begin
            if (bcd_i[d*4 +: 4] >= 4'd5) begin
                adj[d*4 +: 4] = bcd_i[d*4 +: 4] + 4'd3;
            end
        end
    end

    assign bcd_o = {adj[DIGITS*4-2:0], bin_i[DATA_W-1]};
    assign bin_o = {bin_i[DATA_W-2:0], 1'b0};

endmodule

// File: rtl/matrix_bcd_loader.sv
// Fetches matrix elements, converts them to BCD and commits the
// whole digit bus to the renderers during vertical blanking.
module matrix_bcd_loader
    import matrix_bcd_loader_pkg::*;
#(
    parameter int MATRIX_N = 3,
    parameter int MATRIX_M = 3,
    parameter int NUM_MATS = 3,
    parameter int DIGITS   = 5,
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 5,
    parameter int LZ_BLANK = 1
) (
    input  logic                                          clk,
    input  logic                                          reset_n,
    input  logic                                          start,
    input  logic                                          vblank,
    output logic                                          mem_rd_en,
    output logic [ADDR_W-1:0]                             mem_addr,
    input  logic [DATA_W-1:0]                             mem_rdata,
    output logic                                          busy,
    output logic                                          done,
    output logic [NUM_MATS*MATRIX_N*MATRIX_M*DIGITS*4-1:0] bcd_out
);

    localparam int unsigned E = elem_count(NUM_MATS, MATRIX_N, MATRIX_M);
    localparam int BW    = DIGITS * 4;
    localparam int TOT_W = NUM_MATS * MATRIX_N * MATRIX_M * DIGITS * 4;
    localparam int SW    = $clog2(TOT_W);
    localparam int CW    = $clog2(DATA_W);
    localparam int IW    = $clog2(MATRIX_N + 1);
    localparam int JW    = $clog2(NUM_MATS + 1);
    localparam int KW    = $clog2(MATRIX_M + 1);

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [IW-1:0]     i_q, i_d;
    logic [JW-1:0]     j_q, j_d;
    logic [KW-1:0]     k_q, k_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0] bin_q, bin_d;
    logic [BW-1:0]     bcd_q, bcd_d;
    logic [TOT_W-1:0]  shadow_q, shadow_d;
    logic [TOT_W-1:0]  out_q, out_d;

    logic [BW-1:0]     step_bcd;
    logic [DATA_W-1:0] step_bin;
    logic [SW-1:0]     ebase;

    bcd_dabble_step #(
        .DIGITS(DIGITS),
        .DATA_W(DATA_W)
    ) u_step (
        .bcd_i(bcd_q),
        .bin_i(bin_q),
        .bcd_o(step_bcd),
        .bin_o(step_bin)
    );

    // Reorders to MSD-first slot layout and blanks leading zeros
    function automatic logic [BW-1:0] to_slot(input logic [BW-1:0] bcd);
        logic [BW-1:0] s;
        logic          seen;
        logic [3:0]    dg;
        s    = '0;
        seen = 1'b0;
        for (int l = 0; l < DIGITS; l++) begin
            dg = bcd[(DIGITS-1-l)*4 +: 4];
            if (dg != 4'd0) seen = 1'b1;
            if (LZ_BLANK != 0 && !seen && l != DIGITS - 1) dg = 4'hF;
            s[l*4 +: 4] = dg;
        end
        return s;
    endfunction

    assign ebase = SW'(slot_base(32'(i_q), 32'(j_q), 32'(k_q), 0,
                                 NUM_MATS, MATRIX_M, DIGITS));

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        i_d      = i_q;
        j_d      = j_q;
        k_d      = k_q;
        cnt_d    = cnt_q;
        bin_d    = bin_q;
        bcd_d    = bcd_q;
        shadow_d = shadow_q;
        out_d    = out_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_READ;
                    addr_d  = '0;
                    i_d     = '0;
                    j_d     = '0;
                    k_d     = '0;
                end
            end
            S_READ: state_d = S_WAIT;
            S_WAIT: begin
                bin_d   = mem_rdata;
                bcd_d   = '0;
                cnt_d   = '0;
                state_d = S_CONV;
            end
            S_CONV: begin
                bcd_d = step_bcd;
                bin_d = step_bin;
                if (cnt_q == CW'(DATA_W - 1)) state_d = S_STORE;
                else cnt_d = cnt_q + CW'(1);
            end
            S_STORE: begin
                shadow_d[ebase +: BW] = to_slot(bcd_q);
                if (addr_q == ADDR_W'(E - 1)) begin
                    state_d = S_PEND;
                end else begin
                    state_d = S_READ;
                    addr_d  = addr_q + ADDR_W'(1);
                    if (k_q == KW'(MATRIX_M - 1)) begin
                        k_d = '0;
                        if (i_q == IW'(MATRIX_N - 1)) begin
                            i_d = '0;
                            j_d = j_q + JW'(1);
                        end else begin
                            i_d = i_q + IW'(1);
                        end
                    end else begin
                        k_d = k_q + KW'(1);
                    end
                end
            end
            S_PEND: if (vblank) state_d = S_COMMIT;
            S_COMMIT: begin
                out_d   = shadow_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            i_q      <= '0;
            j_q      <= '0;
            k_q      <= '0;
            cnt_q    <= '0;
            bin_q    <= '0;
            bcd_q    <= '0;
            shadow_q <= '1;
            out_q    <= '1;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            i_q      <= i_d;
            j_q      <= j_d;
            k_q      <= k_d;
            cnt_q    <= cnt_d;
            bin_q    <= bin_d;
            bcd_q    <= bcd_d;
            shadow_q <= shadow_d;
            out_q    <= out_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_COMMIT);
    assign mem_rd_en = (state_q == S_READ);
    assign mem_addr  = addr_q;
    assign bcd_out   = out_q;

endmodule

// File: tb/tb_matrix_bcd_loader.sv
// Directed bench for matrix_bcd_loader: vector table plus
// hand-written sequences for vblank, start and reset corners.
module tb_matrix_bcd_loader;

    localparam int DW  = 16;
    localparam int AW  = 5;
    localparam int E   = 27;
    localparam int TOT = E * 5 * 4;

    logic           clk = 1'b0;
    logic           reset_n = 1'b1;
    logic           start = 1'b0;
    logic           vblank = 1'b0;
    logic           rd0, rd1, busy0, busy1, done0, done1;
    logic [AW-1:0]  addr0, addr1;
    logic [DW-1:0]  rdata0 = '0;
    logic [DW-1:0]  rdata1 = '0;
    logic [TOT-1:0] bus0, bus1;
    logic [DW-1:0]  mem [32];

    int checks = 0;
    int errors = 0;
    int last_done_n = -1;

    typedef struct {
        int          addr;
        bit          lz;
        logic [19:0] exp;
    } vec_t;
    vec_t vecs[15];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rd0) rdata0 <= mem[addr0];
        if (rd1) rdata1 <= mem[addr1];
    end

    matrix_bcd_loader #(.LZ_BLANK(1)) dut0 (
        .clk(clk), .reset_n(reset_n), .start(start), .vblank(vblank),
        .mem_rd_en(rd0), .mem_addr(addr0), .mem_rdata(rdata0),
        .busy(busy0), .done(done0), .bcd_out(bus0)
    );

    matrix_bcd_loader #(.LZ_BLANK(0)) dut1 (
        .clk(clk), .reset_n(reset_n), .start(start), .vblank(vblank),
        .mem_rd_en(rd1), .mem_addr(addr1), .mem_rdata(rdata1),
        .busy(busy1), .done(done1), .bcd_out(bus1)
    );

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_bus(input string nm, input logic [TOT-1:0] act,
                           input logic [TOT-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic int base_of(input int a);
        return ((((a % 9) / 3) * 3 + a / 9) * 3 + a % 3) * 20;
    endfunction

    function automatic logic [19:0] get_dig(input logic [TOT-1:0] b,
                                            input int a);
        logic [19:0] r;
        int          bs;
        bs = base_of(a);
        for (int l = 0; l < 5; l++) r[(4-l)*4 +: 4] = b[bs + 4*l +: 4];
        return r;
    endfunction

    // Decimal model of the committed bus from current memory contents
    function automatic logic [TOT-1:0] model_bus(input bit lz);
        logic [TOT-1:0] b;
        int             v, bs;
        int             d[5];
        bit             seen;
        b = '1;
        for (int a = 0; a < E; a++) begin
            v = int'(mem[a]);
            for (int l = 4; l >= 0; l--) begin
                d[l] = v % 10;
                v    = v / 10;
            end
            seen = 1'b0;
            bs   = base_of(a);
            for (int l = 0; l < 5; l++) begin
                if (d[l] != 0) seen = 1'b1;
                if (lz && !seen && l < 4) d[l] = 15;
                b[bs + 4*l +: 4] = 4'(d[l]);
            end
        end
        return b;
    endfunction

    task automatic run_load(input string tag, input int max_n,
                            input bit poke);
        int rdc;
        rdc = 0;
        last_done_n = -1;
        start = 1'b1;
        for (int n = 1; n <= max_n; n++) begin
            tick;
            if (!poke && n == 1) start = 1'b0;
            if (poke) begin
                if (n == 2 || n == 6 || n == 515) start = 1'b0;
                if (n == 5 || n == 514) start = 1'b1;
            end
            if (rd0) begin
                chk({tag, " addr"}, 64'(addr0), 64'(rdc));
                chk({tag, " rd cycle"}, 64'(n), 64'(1 + 19 * rdc));
                rdc++;
            end
            if (done0) begin
                last_done_n = n;
                break;
            end
        end
        start = 1'b0;
        chk({tag, " rd count"}, 64'(rdc), 64'(E));
    endtask

    logic [TOT-1:0] old_bus;

    initial begin
        for (int a = 0; a < 32; a++) mem[a] = 16'd42;
        mem[0] = 16'd0;     mem[1] = 16'd1;
        mem[2] = 16'd9;     mem[3] = 16'd10;
        mem[4] = 16'd99;    mem[5] = 16'd100;
        mem[6] = 16'd12345; mem[7] = 16'd65535;
        mem[21] = 16'd7;

        vecs[0]  = '{0, 1'b1, 20'hFFFF0};
        vecs[1]  = '{1, 1'b1, 20'hFFFF1};
        vecs[2]  = '{2, 1'b1, 20'hFFFF9};
        vecs[3]  = '{3, 1'b1, 20'hFFF10};
        vecs[4]  = '{4, 1'b1, 20'hFFF99};
        vecs[5]  = '{5, 1'b1, 20'hFF100};
        vecs[6]  = '{6, 1'b1, 20'h12345};
        vecs[7]  = '{7, 1'b1, 20'h65535};
        vecs[8]  = '{8, 1'b1, 20'hFFF42};
        vecs[9]  = '{21, 1'b1, 20'hFFFF7};
        vecs[10] = '{26, 1'b1, 20'hFFF42};
        vecs[11] = '{2, 1'b0, 20'h00009};
        vecs[12] = '{0, 1'b0, 20'h00000};
        vecs[13] = '{5, 1'b0, 20'h00100};
        vecs[14] = '{7, 1'b0, 20'h65535};

        #1 reset_n = 1'b0;
        #1;
        chk_bus("reset bus lz1", bus0, '1);
        chk_bus("reset bus lz0", bus1, '1);
        chk("reset busy", 64'(busy0), 64'(0));
        chk("reset done", 64'(done0), 64'(0));
        chk("reset rd_en", 64'(rd0), 64'(0));
        chk("reset addr", 64'(addr0), 64'(0));
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        tick;

        // Load 1: vblank high, start poked during READ, CONV, PEND
        vblank = 1'b1;
        run_load("load1", 600, 1'b1);
        chk("load1 done cycle", 64'(last_done_n), 64'(515));
        start = 1'b1;
        tick;
        start = 1'b0;
        chk("commit start ignored", 64'(busy0), 64'(0));
        chk("done single pulse", 64'(done0), 64'(0));
        chk_bus("load1 bus lz1", bus0, model_bus(1'b1));
        chk_bus("load1 bus lz0", bus1, model_bus(1'b0));
        tick;
        chk("idle stays idle", 64'(busy0), 64'(0));
        for (int v = 0; v < 15; v++) begin
            chk($sformatf("vec%0d addr%0d", v, vecs[v].addr),
                64'(get_dig(vecs[v].lz ? bus0 : bus1, vecs[v].addr)),
                64'(vecs[v].exp));
        end
        chk("slot bit 316", 64'(bus0[316 +: 4]), 64'(4'h7));

        // Load 2: vblank held low long after PEND
        old_bus = model_bus(1'b1);
        mem[0] = 16'd5;
        vblank = 1'b0;
        run_load("load2", 514 + 2000, 1'b0);
        chk("vblank low no done", 64'(last_done_n), 64'hFFFF_FFFF_FFFF_FFFF);
        chk("vblank low busy", 64'(busy0), 64'(1));
        chk_bus("vblank low bus held", bus0, old_bus);
        vblank = 1'b1;
        tick;
        chk("commit done", 64'(done0), 64'(1));
        chk("commit busy", 64'(busy0), 64'(1));
        chk_bus("commit bus not yet", bus0, old_bus);
        tick;
        chk("after commit done", 64'(done0), 64'(0));
        chk("after commit busy", 64'(busy0), 64'(0));
        chk_bus("load2 bus", bus0, model_bus(1'b1));
        chk("load2 elem0", 64'(get_dig(bus0, 0)), 64'(20'hFFFF5));

        // Load 3: start one cycle after the done cycle
        mem[0] = 16'd0;
        run_load("load3", 600, 1'b0);
        chk("load3 done cycle", 64'(last_done_n), 64'(515));
        tick;
        chk_bus("load3 bus", bus0, model_bus(1'b1));

        // Reset asserted mid-conversion
        mem[4] = 16'd3;
        start = 1'b1;
        tick;
        start = 1'b0;
        repeat (4) tick;
        #2 reset_n = 1'b0;
        #1;
        chk_bus("midreset bus", bus0, '1);
        chk("midreset busy", 64'(busy0), 64'(0));
        chk("midreset done", 64'(done0), 64'(0));
        chk("midreset rd_en", 64'(rd0), 64'(0));
        chk("midreset addr", 64'(addr0), 64'(0));
        @(negedge clk);
        reset_n = 1'b1;
        run_load("reload", 600, 1'b0);
        chk("reload done cycle", 64'(last_done_n), 64'(515));
        tick;
        chk_bus("reload bus lz1", bus0, model_bus(1'b1));
        chk_bus("reload bus lz0", bus1, model_bus(1'b0));
        chk("reload elem4", 64'(get_dig(bus0, 4)), 64'(20'hFFFF3));

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/matrix_bcd_loader.md
Name: matrix_bcd_loader

Overview:
- Upstream feeder for the matrix text display.
- Fetches the unsigned binary matrix elements from a result memory and converts each to DIGITS BCD digits with a sequential double-dabble engine.
- Stores the digits in a shadow register file and commits them to the flat BCD bus driving the digit renderers, only during vertical blanking, so the display never tears.

Parameters:
- MATRIX_N, 3, rows per matrix
- MATRIX_M, 3, columns per matrix
- NUM_MATS, 3, matrices displayed side by side (A, B, result)
- DIGITS, 5, decimal digits per element
- DATA_W, 16, element width, unsigned; 2^DATA_W-1 must fit in DIGITS digits
- ADDR_W, 5, memory address width; must satisfy 2^ADDR_W >= NUM_MATS*MATRIX_N*MATRIX_M
- LZ_BLANK, 1, 1 = replace leading zeros with 4'hF (renderer draws blank)

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to reload all elements
- vblank  in  1  vertical blanking level from the vertical counter
- mem_rd_en  out  1  memory read strobe
- mem_addr  out  ADDR_W  element address
- mem_rdata  in  DATA_W  read data, valid exactly 1 cycle after mem_rd_en
- busy  out  1  high from accepted start until commit
- done  out  1  one-cycle pulse on the commit cycle
- bcd_out  out  NUM_MATS*MATRIX_N*MATRIX_M*DIGITS*4  committed digits

Behaviour:
- Reset (async, any state): FSM to IDLE; busy=0, done=0, mem_rd_en=0, mem_addr=0; bcd_out and shadow all 4'hF. An in-flight load is discarded and nothing is committed.
- Element order: matrix j outer, row i, column k inner.
  - mem_addr = j*N*M + i*M + k.
- bcd_out slot for (row i, matrix j, column k, digit l):
  - base bit = (((i*NUM_MATS + j)*M + k)*DIGITS + l)*4.
  - l=0 is the most-significant (leftmost) digit.
- FSM states: IDLE, READ, WAIT, CONV, STORE, PEND, COMMIT.
  - IDLE: start=1 → READ, busy=1. start is ignored in every other state.
  - READ (1 cycle): mem_rd_en=1, mem_addr=current element → WAIT.
  - WAIT (1 cycle): capture mem_rdata into the shift register; clear the BCD accumulator → CONV.
  - CONV (DATA_W cycles): each cycle, add 3 to every BCD nibble ≥5, then shift {bcd, bin} left by 1. A bit counter tracks iterations; after the last iteration → STORE.
  - STORE (1 cycle): apply leading-zero blanking if LZ_BLANK and write the DIGITS nibbles into the shadow.
    - Blanking replaces every zero digit left of the first nonzero digit with 4'hF; the least-significant digit is never blanked, so value 0 shows "0".
    - Last element → PEND; otherwise advance the element index → READ.
  - PEND: wait while vblank=0. On the first cycle with vblank=1 → COMMIT. If vblank is already high on entry, commit the next cycle.
  - COMMIT (1 cycle): bcd_out ← shadow (whole bus in one cycle), done=1, busy=0 from the next cycle → IDLE.
- Latency: 19 cycles per element; the first PEND cycle is 1 + 19*E cycles after start is sampled (E = element count; 514 for 27). Commit latency is then 1 cycle plus the wait for vblank.
- bcd_out changes only in COMMIT; it holds its value through IDLE and the whole load.
- start in the same cycle as COMMIT is ignored, because the FSM is not yet in IDLE.
- Arithmetic: the BCD accumulator is DIGITS*4 bits, with no overflow for legal parameters.

Decomposition:
- Shared package: FSM state encoding, element count constant E = NUM_MATS*MATRIX_N*MATRIX_M, and a slot-index function (i,j,k,l → bit base) reused by the display top.
- One sub-module, bcd_dabble_step: combinational add-3-and-shift of one iteration, DIGITS-generic. The FSM, counters and registers stay in matrix_bcd_loader.

Test Plan:
- Reset → bcd_out all 4'hF, busy=0, done=0, mem_rd_en=0, mem_addr=0; reassert reset mid-CONV → same values immediately, next start performs a full reload.
- Memory model holds 0,1,9,10,99,100,12345,65535 and 42 elsewhere; start, vblank=1 → with LZ_BLANK=1, element 0 digits F,F,F,F,0; 65535 → 6,5,5,3,5; 10 → F,F,F,1,0; with LZ_BLANK=0, 9 → 0,0,0,0,9.
- Address sequence check: mem_addr steps 0..26, mem_rd_en pulses exactly 27 times, 19 cycles apart; first PEND cycle occurs 514 cycles after start.
- vblank held 0 for 2000 cycles after PEND → bcd_out unchanged, done=0, busy=1; raise vblank → bcd_out updates 1 cycle later with a single done pulse, busy falls.
- Pulse start during READ, CONV and PEND → no restart, load count and addresses unaffected; start one cycle after done → new load begins.
- Slot mapping: element (row 1, matrix 2, col 0) = 7 → digit 4 at bit base (((1*3+2)*3+0)*5+4)*4 = 316 holds 4'h7.
